paralelo_serial_tx: RTL and testbench

PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

---
 rtl/paralelo_serial_tx_pkg.sv | 20 ++
 rtl/paralelo_serial_tx_fifo.sv | 67 ++++++
 rtl/paralelo_serial_tx.sv | 136 +++++++++++++
 tb/tb_paralelo_serial_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/paralelo_serial_tx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : paralelo_serial_tx_pkg
// Brief    : Shared state encoding and slot constants for the serial transmitter
// Revision : 1.0
// ============================================================================
package paralelo_serial_tx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t     c_ST_ZERO       = 2'd0;
    localparam state_t     c_ST_SYNC       = 2'd1;
    localparam state_t     c_ST_ACTIVE     = 2'd2;

    localparam logic [7:0] c_COMMA_DEFAULT = 8'hBC;
    localparam logic [7:0] c_ZERO_SLOT     = 8'h00;

endpackage
`default_nettype wire

// File: rtl/paralelo_serial_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tx_byte_fifo
// Brief    : Power-of-two byte FIFO with first-word-fall-through head output
// Revision : 1.0
// ============================================================================
module tx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    output logic [7:0] data,
    output logic       full,
    output logic       empty
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_LVL_ONE = 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = 1;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_level;
    logic            w_do_push;
    logic            w_do_pop;

    // Status comes from the registered level only, so a same-cycle pop never frees a slot
    assign full      = (r_level == c_FULL);
    assign empty     = (r_level == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign data      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/paralelo_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : paralelo_serial_tx
// Brief    : Byte-to-serial transmitter: zero slot, comma sync, then buffered
//            data MSB first. Define SKIP_INSERT_EN to force a comma slot after
//            every 15 consecutive data slots.
// Revision : 1.0
// ============================================================================
module paralelo_serial_tx
    import paralelo_serial_tx_pkg::*;
#(
    parameter int         SYNC_COMMAS = 4,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] COMMA       = c_COMMA_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out
);

    localparam logic [3:0] c_SYNC_LAST = 4'(SYNC_COMMAS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_count;
    logic [3:0] r_sync_cnt;
    logic [3:0] w_sync_cnt_nxt;
    logic [7:0] r_slot;
    logic       r_data_out;
    logic       r_active;
    logic [7:0] w_next_byte;
    logic       w_slot_end;
    logic       w_pop;
    logic       w_push;
    logic       w_force_comma;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [7:0] w_fifo_head;

    assign w_slot_end = (r_count == 3'd7);
    assign w_push     = valid_in && !w_fifo_full;
    assign ready_out  = !w_fifo_full;
    assign data_out   = r_data_out;
    assign active_out = r_active;

    tx_byte_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_32f),
        .rst_n     (reset_L),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (data_in),
        .data      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // State register, bit counter and shifter
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= c_ST_ZERO;
            r_count    <= 3'd0;
            r_sync_cnt <= 4'd0;
            r_slot     <= c_ZERO_SLOT;
            r_data_out <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
            r_count    <= r_count + 3'd1;
            if (w_slot_end) begin
                r_slot     <= w_next_byte;
                r_data_out <= w_next_byte[7];
                r_active   <= (w_state_nxt == c_ST_ACTIVE);
            end else begin
                r_data_out <= r_slot[3'd6 - r_count];
            end
        end
    end

    // Next-state: transitions only at slot boundaries; r_sync_cnt counts commas already chosen
    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        if (w_slot_end) begin
            case (r_state)
                c_ST_ZERO: begin
                    w_state_nxt    = c_ST_SYNC;
                    w_sync_cnt_nxt = 4'd1;
                end
                c_ST_SYNC: begin
                    if (r_sync_cnt >= c_SYNC_LAST) begin
                        w_state_nxt = c_ST_ACTIVE;
                    end else begin
                        w_sync_cnt_nxt = r_sync_cnt + 4'd1;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Output decode: which byte fills the next slot and whether it pops the FIFO
    always_comb begin
        w_next_byte = COMMA;
        w_pop       = 1'b0;
        if (w_slot_end && (w_state_nxt == c_ST_ACTIVE) && !w_fifo_empty && !w_force_comma) begin
            w_next_byte = w_fifo_head;
            w_pop       = 1'b1;
        end
    end

`ifdef SKIP_INSERT_EN
    logic [3:0] r_data_run;

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_data_run <= 4'd0;
        end else if (w_slot_end && (w_state_nxt == c_ST_ACTIVE)) begin
            r_data_run <= w_pop ? (r_data_run + 4'd1) : 4'd0;
        end
    end

    assign w_force_comma = (r_data_run == 4'd15);
`else
    assign w_force_comma = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_paralelo_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_paralelo_serial_tx
// Brief    : Directed self-checking bench for paralelo_serial_tx
// Revision : 1.0
// ============================================================================
module tb_paralelo_serial_tx;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       active_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit stream_on = 1'b0;

    always #5 clk_32f = ~clk_32f;

    paralelo_serial_tx dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .active_out (active_out)
    );

    // One clock; in stream mode the next byte is presented after each accept
    task automatic step();
        logic w_rdy;
        w_rdy = ready_out;
        @(posedge clk_32f);
        @(negedge clk_32f);
        if (stream_on && valid_in && w_rdy) data_in = data_in + 8'd1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset_L = 1'b0;
        repeat (3) @(negedge clk_32f);
        reset_L = 1'b1;
        cyc = 0;
    endtask

    // Collects one slot starting at count 0; optional single push at count push_at
    task automatic read_slot(input int push_at, input logic [7:0] push_byte, output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            b[7-i] = data_out;
            if (i == push_at) begin
                valid_in = 1'b1;
                data_in  = push_byte;
            end
            step();
            if (i == push_at) valid_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        #3;
        total++; if (data_out !== 1'b0) begin bad++; $display("FAIL reset_data_out: got %b expected 0", data_out); end
        total++; if (active_out !== 1'b0) begin bad++; $display("FAIL reset_active: got %b expected 0", active_out); end
        do_reset();
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
    endtask

    task automatic test_sync_sequence();
        logic [7:0] b;
        logic [7:0] exp_b;
        logic       exp_a;
        do_reset();
        for (int s = 1; s <= 7; s++) begin
            exp_a = (s >= 6);
            total++; if (active_out !== exp_a) begin bad++; $display("FAIL sync_active slot %0d: got %b expected %b", s, active_out, exp_a); end
            read_slot(-1, 8'h00, b);
            exp_b = (s == 1) ? 8'h00 : 8'hBC;
            total++; if (b !== exp_b) begin bad++; $display("FAIL sync_slot %0d: got %h expected %h", s, b, exp_b); end
        end
    endtask

    task automatic test_push_in_sync();
        logic [7:0] b;
        logic [7:0] exp_b [8];
        exp_b = '{8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hFF, 8'hEE, 8'hBC};
        do_reset();
        for (int s = 0; s < 8; s++) begin
            if (s == 1)      read_slot(2, 8'hFF, b);
            else if (s == 2) read_slot(3, 8'hEE, b);
            else             read_slot(-1, 8'h00, b);
            total++; if (b !== exp_b[s]) begin bad++; $display("FAIL sync_push slot %0d: got %h expected %h", s + 1, b, exp_b[s]); end
        end
    endtask

    task automatic test_latency();
        logic [7:0] b;
        logic [7:0] exp_b [5];
        exp_b = '{8'hBC, 8'h5A, 8'hBC, 8'hBC, 8'hA5};
        do_reset();
        for (int s = 0; s < 6; s++) read_slot(-1, 8'h00, b);
        for (int s = 0; s < 5; s++) begin
            if (s == 0)      read_slot(6, 8'h5A, b);
            else if (s == 2) read_slot(7, 8'hA5, b);
            else             read_slot(-1, 8'h00, b);
            total++; if (b !== exp_b[s]) begin bad++; $display("FAIL latency slot %0d: got %h expected %h", s + 7, b, exp_b[s]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] exp_b;
        logic [7:0] nxt;
        int         run;
        @(negedge clk_32f);
        stream_on = 1'b1;
        valid_in  = 1'b1;
        data_in   = 8'h01;
        do_reset();
        repeat (3) step();
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL b2b_ready_3: got %b expected 1", ready_out); end
        step();
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL b2b_ready_4: got %b expected 0", ready_out); end
        while (cyc < 39) step();
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL b2b_ready_39: got %b expected 0", ready_out); end
        step();
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL b2b_ready_40: got %b expected 1", ready_out); end
        nxt = 8'h01;
        run = 0;
        for (int s = 0; s < 17; s++) begin
            read_slot(-1, 8'h00, b);
`ifdef SKIP_INSERT_EN
            if (run == 15) begin
                exp_b = 8'hBC;
                run   = 0;
            end else begin
                exp_b = nxt;
                nxt   = nxt + 8'd1;
                run++;
            end
`else
            exp_b = nxt;
            nxt   = nxt + 8'd1;
            run++;
`endif
            total++; if (b !== exp_b) begin bad++; $display("FAIL b2b slot %0d: got %h expected %h", s + 6, b, exp_b); end
        end
        stream_on = 1'b0;
        valid_in  = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [7:0] exp_b;
        do_reset();
        valid_in = 1'b1;
        data_in = 8'h11; step();
        data_in = 8'h22; step();
        data_in = 8'h33; step();
        valid_in = 1'b0;
        repeat (8) step();
        total++; if (data_out !== 1'b1) begin bad++; $display("FAIL mid_pre_bit: got %b expected 1", data_out); end
        reset_L = 1'b0;
        #1;
        total++; if (data_out !== 1'b0) begin bad++; $display("FAIL mid_async_data_out: got %b expected 0", data_out); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b expected 1", ready_out); end
        repeat (2) @(negedge clk_32f);
        reset_L = 1'b1;
        cyc = 0;
        for (int s = 1; s <= 7; s++) begin
            read_slot(-1, 8'h00, b);
            exp_b = (s == 1) ? 8'h00 : 8'hBC;
            total++; if (b !== exp_b) begin bad++; $display("FAIL mid_slot %0d: got %h expected %h", s, b, exp_b); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_sync_sequence();
        test_push_in_sync();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
